// File: rtl/shift_pkg.sv
// Shared constants and helpers for the universal shift register block.
package shift_pkg;

    // Operation select codes sampled on each enabled clock edge.
    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_ROL   = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_LOAD  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;
    localparam logic [2:0] MODE_RSVD  = 3'b111;

    // Width of a counter able to hold 0..width.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_frame_cnt.sv
// Shift counter for the universal shift register: counts shifts since the last
// restart and emits a one-cycle frame_done pulse when a full frame has shifted.
module shift_frame_cnt
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      shift,
    input  logic                      restart,
    output logic [cnt_w(WIDTH)-1:0]   bit_cnt,
    output logic                      frame_done
);

    localparam int unsigned     CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_d;
    logic          done_d;

    // Next count: restart beats a would-be frame wrap; the pulse only follows a wrap.
    always_comb begin
        cnt_d  = bit_cnt;
        done_d = 1'b0;
        if (restart) begin
            cnt_d = '0;
        end else if (shift) begin
            if (bit_cnt == LAST) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = bit_cnt + CW'(1);
            end
        end
    end

    // Counter and pulse registers; reset drops any partial frame silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            bit_cnt    <= cnt_d;
            frame_done <= done_d;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift, rotate, load and clear selected per cycle,
// with a frame counter that pulses after every WIDTH shifts.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [2:0]                mode,
    input  logic                      ser_in_lsb,
    input  logic                      ser_in_msb,
    input  logic [WIDTH-1:0]          par_in,
    output logic [WIDTH-1:0]          par_out,
    output logic                      ser_out_msb,
    output logic                      ser_out_lsb,
    output logic [cnt_w(WIDTH)-1:0]   bit_cnt,
    output logic                      frame_done
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             shift_stb;
    logic             restart_stb;

    // Datapath next state and counter strobes; en=0 and HOLD/reserved keep everything.
    always_comb begin
        shreg_d     = shreg_q;
        shift_stb   = 1'b0;
        restart_stb = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHL: begin
                    shreg_d   = {shreg_q[WIDTH-2:0], ser_in_lsb};
                    shift_stb = 1'b1;
                end
                MODE_SHR: begin
                    shreg_d   = {ser_in_msb, shreg_q[WIDTH-1:1]};
                    shift_stb = 1'b1;
                end
                MODE_ROL: begin
                    shreg_d   = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
                    shift_stb = 1'b1;
                end
                MODE_ROR: begin
                    shreg_d   = {shreg_q[0], shreg_q[WIDTH-1:1]};
                    shift_stb = 1'b1;
                end
                MODE_LOAD: begin
                    shreg_d     = par_in;
                    restart_stb = 1'b1;
                end
                MODE_CLEAR: begin
                    shreg_d     = RESET_VAL;
                    restart_stb = 1'b1;
                end
                default: begin
                    // HOLD and the reserved code leave state untouched.
                end
            endcase
        end
    end

    // Register state; synchronous reset dominates enable and mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= RESET_VAL;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign par_out     = shreg_q;
    assign ser_out_msb = shreg_q[WIDTH-1];
    assign ser_out_lsb = shreg_q[0];

    shift_frame_cnt #(
        .WIDTH (WIDTH)
    ) u_frame_cnt (
        .clk        (clk),
        .rst        (rst),
        .shift      (shift_stb),
        .restart    (restart_stb),
        .bit_cnt    (bit_cnt),
        .frame_done (frame_done)
    );

endmodule
